// File: rtl/rv_pkg.sv
// Shared pipeline types: memory-op control bundle, data-memory responder state,
// and the byte-lane helpers used by the responder.
package rv_pkg;

    typedef enum logic [1:0] {
        BYTE  = 2'b00,
        HWORD = 2'b01,
        WORD  = 2'b10
    } mem_op_sz_e;

    typedef struct packed {
        logic       sign_ext;
        logic [1:0] rw_sz;
        logic       mem_read;
        logic       mem_write;
    } mem_ctrl_reg_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_e;

    function automatic logic [3:0] sz_be(logic [1:0] sz, logic [1:0] a);
        case (sz)
            BYTE:    return 4'b0001 << a;
            HWORD:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] st_lanes(logic [1:0] sz, logic [31:0] wd);
        case (sz)
            BYTE:    return {4{wd[7:0]}};
            HWORD:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] ld_ext(logic [1:0] sz, logic sx,
                                           logic [1:0] a, logic [31:0] raw);
        logic [31:0] sh;
        case (sz)
            BYTE: begin
                sh = raw >> {a, 3'b000};
                return {{24{sx & sh[7]}}, sh[7:0]};
            end
            HWORD: begin
                sh = raw >> {a[1], 4'b0000};
                return {{16{sx & sh[15]}}, sh[15:0]};
            end
            default: return raw;
        endcase
    endfunction

    function automatic logic misaligned(logic [1:0] sz, logic [1:0] a);
        case (sz)
            BYTE:    return 1'b0;
            HWORD:   return a[0];
            default: return |a;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM, 32-bit words with byte enables and a
// registered read port. Contents are never reset.
module dmem_ram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: fixed wait states, lane select, store merge, load extend.
// Optional misaligned-access error reporting under DMEM_MISALIGN_ERR_EN.
module dmem_responder
    import rv_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [63:0]   req_addr,
    input  logic [31:0]   req_wdata,
    input  mem_ctrl_reg_t req_ctrl,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic          stall
);

    dmem_state_e       state_q, state_d;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    mem_ctrl_reg_t     ctrl_q;

    logic              accept;
    logic              access;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       cur_wd;
    mem_ctrl_reg_t     cur_ctrl;
    logic              cur_ok;
    logic              rsp_ok;
    logic              ram_we;
    logic [31:0]       ram_rdata;
    logic              unused_bits;

    assign accept = req_valid && state_q == IDLE
                 && (req_ctrl.mem_read || req_ctrl.mem_write);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept)
                cnt_q <= 4'(WAIT_CYCLES);
            else if (state_q == WAIT)
                cnt_q <= cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= req_addr[ADDR_W-1:0];
            wdata_q <= req_wdata;
            ctrl_q  <= req_ctrl;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT:    if (cnt_q == 4'd1) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With zero wait states the access happens on the accept edge itself,
    // so the live request must feed the RAM instead of the latched copy.
    assign cur_addr = (state_q == IDLE) ? req_addr[ADDR_W-1:0] : addr_q;
    assign cur_wd   = (state_q == IDLE) ? req_wdata : wdata_q;
    assign cur_ctrl = (state_q == IDLE) ? req_ctrl : ctrl_q;
    assign access   = !rst && state_q != RESP && state_d == RESP;

`ifdef DMEM_MISALIGN_ERR_EN
    assign cur_ok = !misaligned(cur_ctrl.rw_sz, cur_addr[1:0]);
    assign rsp_ok = !misaligned(ctrl_q.rw_sz, addr_q[1:0]);
`else
    assign cur_ok = 1'b1;
    assign rsp_ok = 1'b1;
`endif

    assign ram_we = access && cur_ctrl.mem_write && cur_ok;

    dmem_ram #(
        .AW(ADDR_W - 2)
    ) u_ram (
        .clk   (clk),
        .en    (access),
        .we    (ram_we),
        .be    (sz_be(cur_ctrl.rw_sz, cur_addr[1:0])),
        .idx   (cur_addr[ADDR_W-1:2]),
        .wdata (st_lanes(cur_ctrl.rw_sz, cur_wd)),
        .rdata (ram_rdata)
    );

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        stall     = accept;
        unique case (state_q)
            IDLE: req_ready = 1'b1;
            WAIT: stall = 1'b1;
            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = !rsp_ok;
                if (!ctrl_q.mem_write && rsp_ok)
                    rsp_rdata = ld_ext(ctrl_q.rw_sz, ctrl_q.sign_ext,
                                       addr_q[1:0], ram_rdata);
            end
            default: ;
        endcase
    end

    assign unused_bits = ^{req_addr[63:ADDR_W], ctrl_q.mem_read};

endmodule
